// File: rtl/cp0_int_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_int_ctrl
//
// Interrupt controller between the six external devices and CP0.
// It synchronises the asynchronous device request lines and latches them into
// a pending vector, either edge- or level-sensitive per source. It arbitrates
// among the unmasked pending sources and presents one granted source, one-hot,
// on DEV_break_SUM (HWInt[7:2]). It holds that grant until the handler executes
// eret, and then returns a one-cycle acknowledge to the served device.
//
// Register port (word select on cfg_addr):
//   0  MASK[5:0]   RW, reset 6'h3F
//   1  MODE[5:0]   RW, reset 0     (1 = edge, 0 = level)
//   2  PEND[5:0]   read pending; write-1-to-clear, edge-mode bits only
//   3  STATUS      RO: [9:8] FSM state, [2:0] grant index
//   Unused bits read as 0.
//
// Ports:
//   Clk            clock
//   Reset          synchronous, active-high reset
//   dev_irq[5:0]   raw device interrupt lines (asynchronous)
//   Exception      CP0 has taken the exception
//   is_eret        eret in MEM this cycle
//   cfg_we         register write strobe
//   cfg_addr[1:0]  register select
//   cfg_wdata[31:0] write data
//   cfg_rdata[31:0] read data, combinational from cfg_addr
//   DEV_break_SUM[5:0] one-hot granted source to CP0 HWInt[7:2], registered
//   dev_ack[5:0]   one-hot acknowledge pulse, registered
//
// Build option:
//   INTC_ROUNDROBIN_EN  when defined, arbitration starts one past the
//                       last-served source and wraps. The default build uses
//                       fixed priority with bit 0 highest.
// ---------------------------------------------------------------------------
module cp0_int_ctrl #(
  parameter int NSRC        = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NSRC-1:0] dev_irq,
  input  logic            Exception,
  input  logic            is_eret,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  output logic [NSRC-1:0] DEV_break_SUM,
  output logic [NSRC-1:0] dev_ack
);

  localparam int GW = $clog2(NSRC);

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  // Lowest index at or after 'start' (wrapping) with its request bit set.
  function automatic logic [GW-1:0] pick_first(input logic [NSRC-1:0] req,
                                               input logic [GW-1:0]   start);
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int off = 0; off < NSRC; off++) begin
      idx = (int'(start) + off) % NSRC;
      if (!found && req[idx]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] mode_q;
  logic [NSRC-1:0] pend_q,  pend_d;
  logic [NSRC-1:0] sum_q,   sum_d;
  logic [NSRC-1:0] ack_q,   ack_d;
  logic [GW-1:0]   grant_q, grant_d;
  state_t          state_q, state_d;

  logic [NSRC-1:0] sync_lvl;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] grant_oh;
  logic [GW-1:0]   arb_idx;
  logic [GW-1:0]   arb_start;
  logic            wr_mask, wr_mode, wr_pend;
  logic [NSRC-1:0] edge_set, w1c_clr, ack_clr;

  // Upper write-data bits have no backing storage.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata[31:NSRC];

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign elig     = pend_q & mask_q;
  assign grant_oh = NSRC'(1) << grant_q;

  assign wr_mask = cfg_we && (cfg_addr == ADDR_MASK);
  assign wr_mode = cfg_we && (cfg_addr == ADDR_MODE);
  assign wr_pend = cfg_we && (cfg_addr == ADDR_PEND);

  // -------------------------------------------------------------------------
  // Arbitration start point
  // -------------------------------------------------------------------------
`ifdef INTC_ROUNDROBIN_EN
  logic [GW-1:0] last_q;

  // Resetting the pointer to the top source makes bit 0 the first choice.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q <= GW'(NSRC - 1);
    end else if (state_q == SERV && is_eret) begin
      last_q <= grant_q;
    end
  end

  assign arb_start = (last_q == GW'(NSRC - 1)) ? '0 : last_q + GW'(1);
`else
  assign arb_start = '0;
`endif

  assign arb_idx = pick_first(elig, arb_start);

  // -------------------------------------------------------------------------
  // Pending vector
  // Edge bits: a fresh edge beats a same-cycle W1C or ack clear.
  // Level bits: simply follow the synchronised line.
  // -------------------------------------------------------------------------
  assign edge_set = sync_lvl & ~prev_q & mode_q;
  assign w1c_clr  = wr_pend ? (cfg_wdata[NSRC-1:0] & mode_q) : '0;
  assign ack_clr  = ack_d & mode_q;
  assign pend_d   = (mode_q & ((pend_q & ~(w1c_clr | ack_clr)) | edge_set))
                  | (~mode_q & sync_lvl);

  // -------------------------------------------------------------------------
  // FSM next state / outputs
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sum_d   = sum_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_d = arb_idx;
          sum_d   = NSRC'(1) << arb_idx;
          state_d = REQ;
        end else begin
          sum_d   = '0;
        end
      end
      REQ: begin
        // The grant is frozen here; a later, higher source waits for IDLE.
        if (Exception) begin
          state_d = SERV;
        end else if (!pend_q[grant_q] || !mask_q[grant_q]) begin
          state_d = IDLE;
          sum_d   = '0;
        end
      end
      SERV: begin
        // DEV_break_SUM stays put so Cause.IP shows the source to the handler.
        if (is_eret) begin
          state_d = IDLE;
          sum_d   = '0;
          ack_d   = grant_oh;
        end
      end
      default: begin
        state_d = IDLE;
        sum_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q  <= '0;
      prev_q  <= '0;
      mask_q  <= {NSRC{1'b1}};
      mode_q  <= '0;
      pend_q  <= '0;
      sum_q   <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      state_q <= IDLE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], dev_irq};
      prev_q  <= sync_lvl;
      if (wr_mask) mask_q <= cfg_wdata[NSRC-1:0];
      if (wr_mode) mode_q <= cfg_wdata[NSRC-1:0];
      pend_q  <= pend_d;
      sum_q   <= sum_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Register read
  // -------------------------------------------------------------------------
  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      ADDR_MASK:   cfg_rdata[NSRC-1:0] = mask_q;
      ADDR_MODE:   cfg_rdata[NSRC-1:0] = mode_q;
      ADDR_PEND:   cfg_rdata[NSRC-1:0] = pend_q;
      ADDR_STATUS: begin
        cfg_rdata[9:8]    = state_q;
        cfg_rdata[GW-1:0] = grant_q;
      end
      default:     cfg_rdata = '0;
    endcase
  end

  assign DEV_break_SUM = sum_q;
  assign dev_ack       = ack_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_int_ctrl
//
// Directed bench for cp0_int_ctrl (default build: fixed priority). Inputs are
// driven 1 time unit after the rising edge. Outputs are sampled in that same
// window, so each tick() observes the state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_cp0_int_ctrl;

  logic        Clk;
  logic        Reset;
  logic [5:0]  dev_irq;
  logic        Exception;
  logic        is_eret;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic [5:0]  DEV_break_SUM;
  logic [5:0]  dev_ack;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_int_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .dev_irq       (dev_irq),
    .Exception     (Exception),
    .is_eret       (is_eret),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_rdata     (cfg_rdata),
    .DEV_break_SUM (DEV_break_SUM),
    .dev_ack       (dev_ack)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a,
                           input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp);
    logic [31:0] d;
    rd(2'd3, d);
    check(tag, {30'd0, d[9:8]}, {30'd0, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = v;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  // Exception for one cycle, then eret for one cycle.
  task automatic take_and_return();
    Exception = 1'b1;
    tick();
    Exception = 1'b0;
    is_eret   = 1'b1;
    tick();
    is_eret   = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    dev_irq   = '0;
    Exception = 1'b0;
    is_eret   = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    tick(3);
    Reset = 1'b0;

    // ---- reset state ------------------------------------------------------
    check_reg("rst_mask",   2'd0, 32'h3F);
    check_reg("rst_mode",   2'd1, 32'h0);
    check_reg("rst_pend",   2'd2, 32'h0);
    check_reg("rst_status", 2'd3, 32'h0);
    check("rst_sum", {26'd0, DEV_break_SUM}, 32'h0);
    check("rst_ack", {26'd0, dev_ack}, 32'h0);

    // ---- edge source 3: latency, service, ack, pending clear --------------
    wr(2'd1, 32'h3F);
    check_reg("mode_rb", 2'd1, 32'h3F);
    dev_irq = 6'h08;
    tick(2);                                   // posedges k, k+1
    check_reg("e3_pend_early", 2'd2, 32'h0);
    tick();                                    // posedge k+2
    check_reg("e3_pend", 2'd2, 32'h08);
    check("e3_sum_early", {26'd0, DEV_break_SUM}, 32'h0);
    tick();                                    // posedge k+3
    check("e3_sum", {26'd0, DEV_break_SUM}, 32'h08);
    check_reg("e3_status_req", 2'd3, 32'h103);
    dev_irq   = 6'h00;
    Exception = 1'b1;
    tick();
    Exception = 1'b0;
    check_state("e3_serv", 2'd2);
    tick(2);
    check("e3_sum_hold", {26'd0, DEV_break_SUM}, 32'h08);
    check("e3_no_ack", {26'd0, dev_ack}, 32'h0);
    is_eret = 1'b1;
    tick();
    is_eret = 1'b0;
    check("e3_ack", {26'd0, dev_ack}, 32'h08);
    check("e3_sum_drop", {26'd0, DEV_break_SUM}, 32'h0);
    check_reg("e3_pend_clr", 2'd2, 32'h0);
    check_state("e3_idle", 2'd0);
    tick();
    check("e3_ack_1cyc", {26'd0, dev_ack}, 32'h0);
    tick(3);

    // ---- sources 1 and 4 together: fixed priority -------------------------
    dev_irq = 6'h12;
    tick(4);
    check("p14_sum1", {26'd0, DEV_break_SUM}, 32'h02);
    check_reg("p14_pend", 2'd2, 32'h12);
    check_reg("p14_status1", 2'd3, 32'h101);
    take_and_return();
    check("p14_ack1", {26'd0, dev_ack}, 32'h02);
    check("p14_sum_gap", {26'd0, DEV_break_SUM}, 32'h0);
    check_reg("p14_pend_left", 2'd2, 32'h10);
    tick();
    check("p14_sum4", {26'd0, DEV_break_SUM}, 32'h10);
    check_reg("p14_status4", 2'd3, 32'h104);
    check("p14_ack_gone", {26'd0, dev_ack}, 32'h0);
    take_and_return();
    check("p14_ack4", {26'd0, dev_ack}, 32'h10);
    check_reg("p14_pend_none", 2'd2, 32'h0);
    dev_irq = 6'h00;
    tick(4);

    // ---- masked source 0, then unmasked -----------------------------------
    wr(2'd0, 32'h3E);
    dev_irq = 6'h01;
    tick(4);
    check_reg("m0_pend", 2'd2, 32'h01);
    check("m0_sum_masked", {26'd0, DEV_break_SUM}, 32'h0);
    check_state("m0_idle", 2'd0);
    wr(2'd0, 32'h3F);
    check("m0_sum_wr_edge", {26'd0, DEV_break_SUM}, 32'h0);
    tick();
    check("m0_sum", {26'd0, DEV_break_SUM}, 32'h01);
    check_reg("m0_status", 2'd3, 32'h100);
    take_and_return();
    check("m0_ack", {26'd0, dev_ack}, 32'h01);
    dev_irq = 6'h00;
    tick(4);

    // ---- W1C while in REQ withdraws the request without ack ---------------
    dev_irq = 6'h04;
    tick(4);
    check("w_sum", {26'd0, DEV_break_SUM}, 32'h04);
    check_reg("w_status", 2'd3, 32'h102);
    wr(2'd2, 32'h4);
    check_reg("w_pend_clr", 2'd2, 32'h0);
    check_state("w_still_req", 2'd1);
    tick();
    check("w_sum_drop", {26'd0, DEV_break_SUM}, 32'h0);
    check_state("w_idle", 2'd0);
    check("w_no_ack", {26'd0, dev_ack}, 32'h0);
    tick();
    check("w_no_ack2", {26'd0, dev_ack}, 32'h0);
    dev_irq = 6'h00;
    tick(4);

    // ---- W1C and fresh edge on bit 5 in the same cycle --------------------
    check_reg("c5_pend_pre", 2'd2, 32'h0);
    dev_irq = 6'h20;
    tick(2);                                   // k, k+1
    wr(2'd2, 32'h20);                          // k+2: edge sets, W1C clears
    check_reg("c5_pend_kept", 2'd2, 32'h20);
    tick();
    check("c5_sum", {26'd0, DEV_break_SUM}, 32'h20);
    take_and_return();
    check("c5_ack", {26'd0, dev_ack}, 32'h20);
    dev_irq = 6'h00;
    tick(4);

    // ---- level mode: W1C ignored, request withdrawn by the device ---------
    wr(2'd1, 32'h0);
    dev_irq = 6'h02;
    tick(3);
    check_reg("lv_pend", 2'd2, 32'h02);
    wr(2'd2, 32'h02);
    check_reg("lv_w1c_ignored", 2'd2, 32'h02);
    check("lv_sum", {26'd0, DEV_break_SUM}, 32'h02);
    dev_irq = 6'h00;
    tick(3);
    check_reg("lv_pend_follow", 2'd2, 32'h0);
    tick();
    check("lv_sum_drop", {26'd0, DEV_break_SUM}, 32'h0);
    check_state("lv_idle", 2'd0);

    // ---- reset asserted in SERV together with eret ------------------------
    wr(2'd0, 32'h15);
    dev_irq = 6'h01;
    tick(4);
    check("r_sum", {26'd0, DEV_break_SUM}, 32'h01);
    Exception = 1'b1;
    tick();
    Exception = 1'b0;
    check_state("r_serv", 2'd2);
    Reset   = 1'b1;
    is_eret = 1'b1;
    tick();
    check("r_sum_clr", {26'd0, DEV_break_SUM}, 32'h0);
    check("r_no_ack", {26'd0, dev_ack}, 32'h0);
    check_reg("r_status", 2'd3, 32'h0);
    check_reg("r_mask", 2'd0, 32'h3F);
    check_reg("r_pend", 2'd2, 32'h0);
    Reset   = 1'b0;
    is_eret = 1'b0;
    dev_irq = 6'h00;
    tick();
    check("r_no_ack2", {26'd0, dev_ack}, 32'h0);

    // ---- Exception / eret in IDLE are ignored -----------------------------
    Exception = 1'b1;
    is_eret   = 1'b1;
    tick();
    Exception = 1'b0;
    is_eret   = 1'b0;
    check_state("ign_idle", 2'd0);
    check("ign_no_ack", {26'd0, dev_ack}, 32'h0);
    check("ign_sum", {26'd0, DEV_break_SUM}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
